uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter ADDR, default 8'h60, meaning the device address compared against wb_dbus_adr[31:AWIDTH... top bits].
REQ-002 SHALL have parameter AWIDTH, default 8, meaning the width of the address field compared, taken as wb_dbus_adr[31:32-AWIDTH].
REQ-003 SHALL have parameter DIVIDE, default 260, meaning clocks per bit; 260 is 30 MHz / 115200; the minimum is 4.
REQ-004 SHALL have parameter DEPTH, default 16, meaning the receive FIFO depth; it is a power of two.
REQ-005 SHALL have port wb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port wb_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port wb_dbus_adr, input, 32 bits: bus address.
REQ-008 SHALL have port wb_dbus_dat, input, 32 bits: write data.
REQ-009 SHALL have port wb_dbus_sel, input, 4 bits: byte enables; it is ignored.
REQ-010 SHALL have port wb_dbus_we, input, 1 bit: write strobe.
REQ-011 SHALL have port wb_dbus_cyc, input, 1 bit: bus cycle request.
REQ-012 SHALL have port rdt, output, 32 bits: read data; it is 0 whenever ack is 0.
REQ-013 SHALL have port ack, output, 1 bit: single-cycle acknowledge.
REQ-014 SHALL have port rx, input, 1 bit: asynchronous serial input; it idles high.
REQ-015 SHALL have port irq, output, 1 bit: high while the FIFO is not empty.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer; every receiver decision uses the synchronized value.
REQ-017 SHALL implement receiver states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-018 SHALL move IDLE->START when the synchronized rx is 0, and load the bit counter with DIVIDE/2.
REQ-019 SHALL sample rx at counter expiry in START; rx==1 returns to IDLE (glitch reject, no error); rx==0 goes to DATA with the counter reloaded to DIVIDE.
REQ-020 SHALL in DATA sample 8 bits LSB-first, one every DIVIDE clocks at bit centre, then go to STOP.
REQ-021 SHALL in STOP, at bit centre with rx==1, push the byte to the FIFO and return to IDLE.
REQ-022 SHALL in STOP, at bit centre with rx==0, set ferr, discard the byte, and go to WAIT_IDLE.
REQ-023 SHALL leave WAIT_IDLE for IDLE only once rx==1 is sampled.
REQ-024 SHALL, on a push while the FIFO is full (with no pop in the same cycle), drop the new byte, set ovr, and leave FIFO contents unchanged.
REQ-025 SHALL, on a push and a pop in the same cycle, perform both: a full FIFO accepts the byte and sets no ovr; an empty FIFO is not popped; count changes by the net amount.
REQ-026 SHALL wrap the FIFO pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-027 SHALL treat a request as selected when wb_dbus_cyc=1, the address field equals ADDR, and ack was 0 in the previous cycle.
REQ-028 SHALL raise ack for exactly one cycle, in the cycle after a selected request.
REQ-029 SHALL never assert ack on back-to-back cycles.
REQ-030 SHALL use adr[2] as the register select: 0 = DATA, 1 = STATUS.
REQ-031 SHALL, on a DATA read, return {23'b0, valid, byte}, where valid = FIFO not empty.
REQ-032 SHALL pop the FIFO on a DATA read only if it is non-empty, in the ack cycle.
REQ-033 SHALL return STATUS as {count[15:0] in bits 23:8, 5'b0, ferr, ovr, not_empty}; count is zero-extended.
REQ-034 SHALL, on a STATUS write, clear ovr where dat[1]=1 and clear ferr where dat[2]=1; a STATUS write does not affect the FIFO.
REQ-035 SHALL ignore DATA writes, which are still acked.
REQ-036 SHALL drive irq = not_empty, registered.

Reset
REQ-037 SHALL, with wb_rst_n=0, immediately force: state IDLE, FIFO empty (pointers and count 0), ovr=0, ferr=0, ack=0, rdt=0, irq=0, synchronizer flops=1.
REQ-038 SHALL, on reset mid-frame, abandon the frame; after release, reception restarts only on a new falling edge.

Verification
REQ-039 SHALL cover, with DIVIDE=8, sending byte 0xA5 with a valid stop bit: irq rises; a STATUS read returns 0x00000101; a DATA read returns 0x1A5; then irq=0.
REQ-040 SHALL cover a 2-clock low glitch on rx: no push, no ferr, state back to IDLE, and the next valid byte 0x3C is received correctly.
REQ-041 SHALL cover byte 0x55 sent with stop bit 0: ferr=1 and FIFO empty; rx high then byte 0x12 is received; a STATUS write of 0x4 reads back ferr=0.
REQ-042 SHALL cover sending 17 bytes (0x00..0x10) with DEPTH=16 and no reads: count=16, ovr=1; reads return 0x00..0x0F in order; the 17th read returns 0x000 with no pop.
REQ-043 SHALL cover a stop bit completing in the same cycle as a DATA read ack on a full FIFO: the byte is accepted, ovr=0, count stays 16.
REQ-044 SHALL cover wb_rst_n pulsed low during bit 4 of a frame: all outputs return to 0, and no byte appears from the remainder of that frame.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver (8N1) with a receive FIFO behind a single-cycle-ack bus slave.
// Register 0 pops and returns the FIFO head; register 1 holds counters and sticky error flags.
module uart_rx #(
  parameter int                AWIDTH = 8,
  parameter logic [AWIDTH-1:0] ADDR   = 8'h60,
  parameter int                DIVIDE = 260,
  parameter int                DEPTH  = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        rx,
  output logic        irq
);
  localparam int CW = $clog2(DIVIDE);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF = CW'(DIVIDE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVIDE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_s1_q, rx_s2_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
  logic          ack_q, ack_d, req_reg_q, req_reg_d, req_we_q, req_we_d;
  logic [1:0]    req_clr_q, req_clr_d;
  logic [7:0]    mem_q [DEPTH];

  logic push, ferr_set, sel, pop, do_push, full, not_empty, stat_wr;

  logic unused_ok;
  assign unused_ok = ^{wb_dbus_sel, wb_dbus_adr[31-AWIDTH:3], wb_dbus_adr[1:0],
                       wb_dbus_dat[31:3], wb_dbus_dat[0]};

  // Receiver: all decisions on the synchronized line, sampled at bit centres
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: if (!rx_s2_q) begin
        state_d = START;
        cnt_d   = HALF;
      end
      START: if (cnt_q == '0) begin
        state_d = rx_s2_q ? IDLE : DATA;
        cnt_d   = FULL;
        bit_d   = 3'd0;
      end else cnt_d = cnt_q - CW'(1);
      DATA: if (cnt_q == '0) begin
        shift_d = {rx_s2_q, shift_q[7:1]};
        cnt_d   = FULL;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end else cnt_d = cnt_q - CW'(1);
      STOP: if (cnt_q == '0) begin
        if (rx_s2_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = WAIT_IDLE;
        end
      end else cnt_d = cnt_q - CW'(1);
      WAIT_IDLE: if (rx_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus side and FIFO bookkeeping
  always_comb begin
    sel       = wb_dbus_cyc && (wb_dbus_adr[31 -: AWIDTH] == ADDR) && !ack_q;
    ack_d     = sel;
    req_reg_d = sel ? wb_dbus_adr[2] : req_reg_q;
    req_we_d  = sel ? wb_dbus_we : req_we_q;
    req_clr_d = sel ? wb_dbus_dat[2:1] : req_clr_q;
    not_empty = (count_q != '0);
    full      = (count_q == (PW+1)'(DEPTH));
    pop       = ack_q && !req_we_q && !req_reg_q && not_empty;
    stat_wr   = ack_q && req_we_q && req_reg_q;
    // A pop in the same cycle frees the slot a full FIFO needs
    do_push   = push && (!full || pop);
    wr_ptr_d  = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_push && !pop) count_d = count_q + (PW+1)'(1);
    else if (!do_push && pop) count_d = count_q - (PW+1)'(1);
    ovr_d     = (ovr_q & ~(stat_wr & req_clr_q[0])) | (push & full & ~pop);
    ferr_d    = (ferr_q & ~(stat_wr & req_clr_q[1])) | ferr_set;
    irq_d     = (count_d != '0);
  end

  always_comb begin
    rdt = '0;
    if (ack_q) begin
      if (!req_reg_q) rdt = {23'b0, not_empty, mem_q[rd_ptr_q]};
      else            rdt = {8'b0, 16'(count_q), 5'b0, ferr_q, ovr_q, not_empty};
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      req_reg_q <= 1'b0;
      req_we_q  <= 1'b0;
      req_clr_q <= '0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      req_reg_q <= req_reg_d;
      req_we_q  <= req_we_d;
      req_clr_q <= req_clr_d;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign ack = ack_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: serial frames driven on rx, bytes tracked in a
// queue model, popped and compared as the bus reads them back.
module tb_uart_rx;
  localparam int DIV = 8;
  localparam int DEP = 16;

  logic        wb_clk, wb_rst_n;
  logic [31:0] wb_dbus_adr, wb_dbus_dat, rdt;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we, wb_dbus_cyc, ack, rx, irq;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb[$];
  bit ovr_m, ferr_m;

  uart_rx #(.AWIDTH(8), .ADDR(8'h60), .DIVIDE(DIV), .DEPTH(DEP)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_dbus_adr(wb_dbus_adr),
    .wb_dbus_dat(wb_dbus_dat), .wb_dbus_sel(wb_dbus_sel), .wb_dbus_we(wb_dbus_we),
    .wb_dbus_cyc(wb_dbus_cyc), .rdt(rdt), .ack(ack), .rx(rx), .irq(irq));

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  function automatic logic [31:0] adr_of(input bit r);
    return {8'h60, 21'b0, r, 2'b0};
  endfunction

  function automatic logic [31:0] exp_status();
    return {8'h0, 16'(sb.size()), 5'b0, ferr_m, ovr_m, (sb.size() != 0)};
  endfunction

  // Frame: start, 8 data LSB-first, stop; the model is updated once the stop bit is done
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    @(negedge wb_clk); rx = 1'b0;
    repeat (DIV) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge wb_clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge wb_clk);
    rx = 1'b1;
    repeat (4) @(negedge wb_clk);
    if (!stop_ok) ferr_m = 1'b1;
    else if (sb.size() < DEP) sb.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic bus(input bit r, input bit we, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    @(negedge wb_clk);
    wb_dbus_adr = adr_of(r); wb_dbus_dat = wd; wb_dbus_we = we; wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge wb_clk); #1; n++;
    end while (!ack && n < 20);
    if (!ack) begin
      vectors++; miscompares++;
      $display("FAIL bus_timeout ack=%0b required 1", ack);
    end
    rd = rdt;
    wb_dbus_cyc = 1'b0; wb_dbus_we = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #1;
    vectors++;
    if ({ack, irq, rdt} !== 34'd0) begin
      miscompares++; $display("FAIL reset_outputs ack=%0b irq=%0b rdt=%h required 0", ack, irq, rdt);
    end
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (3) @(negedge wb_clk);
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL reset_status got %h required 0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] rd, exp;
    send_frame(8'hA5, 1'b1);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL basic_irq got %b required 1", irq); end
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== 32'h101) begin miscompares++; $display("FAIL basic_status got %h required 00000101", rd); end
    exp = {23'b0, 1'b1, sb.pop_front()};
    bus(1'b0, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp || rd !== 32'h1A5) begin miscompares++; $display("FAIL basic_data got %h required %h", rd, exp); end
    repeat (2) @(negedge wb_clk);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL basic_irq_clear got %b required 0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] rd, exp;
    @(negedge wb_clk); rx = 1'b0;
    repeat (2) @(negedge wb_clk); rx = 1'b1;
    repeat (20) @(negedge wb_clk);
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp_status()) begin miscompares++; $display("FAIL glitch_status got %h required %h", rd, exp_status()); end
    send_frame(8'h3C, 1'b1);
    exp = {23'b0, 1'b1, sb.pop_front()};
    bus(1'b0, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp) begin miscompares++; $display("FAIL glitch_data got %h required %h", rd, exp); end
  endtask

  task automatic test_ferr();
    logic [31:0] rd, exp;
    send_frame(8'h55, 1'b0);
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp_status() || rd !== 32'h4) begin miscompares++; $display("FAIL ferr_status got %h required %h", rd, exp_status()); end
    repeat (10) @(negedge wb_clk);
    send_frame(8'h12, 1'b1);
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp_status()) begin miscompares++; $display("FAIL ferr_status2 got %h required %h", rd, exp_status()); end
    exp = {23'b0, 1'b1, sb.pop_front()};
    bus(1'b0, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp) begin miscompares++; $display("FAIL ferr_data got %h required %h", rd, exp); end
    bus(1'b1, 1'b1, 32'h4, rd);
    ferr_m = 1'b0;
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL ferr_clear got %h required 0", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd, exp;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp_status() || rd !== 32'h1003) begin miscompares++; $display("FAIL ovr_status got %h required %h", rd, exp_status()); end
    for (int i = 0; i < 17; i++) begin
      exp = (sb.size() != 0) ? {23'b0, 1'b1, sb.pop_front()} : 32'h0;
      bus(1'b0, 1'b0, 0, rd);
      vectors++;
      if (rd !== exp) begin miscompares++; $display("FAIL ovr_read%0d got %h required %h", i, rd, exp); end
    end
    bus(1'b1, 1'b1, 32'h2, rd);
    ovr_m = 1'b0;
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL ovr_clear got %h required 0", rd); end
  endtask

  // Ack cycle of a data read lands on the stop-bit push cycle of a frame
  task automatic test_push_pop_full();
    logic [31:0] rd, exp;
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1);
    fork
      send_frame(8'hEE, 1'b1);
      begin
        @(negedge wb_clk);
        repeat (77) @(posedge wb_clk);
        #1;
        wb_dbus_adr = adr_of(1'b0); wb_dbus_we = 1'b0; wb_dbus_cyc = 1'b1;
        exp = {23'b0, 1'b1, sb[0]};
        @(posedge wb_clk); #1;
        vectors++;
        if (ack !== 1'b1 || rdt !== exp) begin
          miscompares++; $display("FAIL pp_read ack=%0b rdt=%h required 1/%h", ack, rdt, exp);
        end
        void'(sb.pop_front());
        wb_dbus_cyc = 1'b0;
      end
    join
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== exp_status() || rd !== 32'h1001) begin miscompares++; $display("FAIL pp_status got %h required %h", rd, exp_status()); end
    for (int i = 0; i < 16; i++) begin
      exp = {23'b0, 1'b1, sb.pop_front()};
      bus(1'b0, 1'b0, 0, rd);
      vectors++;
      if (rd !== exp) begin miscompares++; $display("FAIL pp_drain%0d got %h required %h", i, rd, exp); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    send_frame(8'h77, 1'b1);
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL rmf_irq_pre got %b required 1", irq); end
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(negedge wb_clk);
        repeat (8 * 5 + 4) @(posedge wb_clk);
        #1; wb_rst_n = 1'b0;
        #1;
        vectors++;
        if ({ack, irq, rdt} !== 34'd0) begin
          miscompares++; $display("FAIL rmf_outputs ack=%0b irq=%0b rdt=%h required 0", ack, irq, rdt);
        end
        repeat (2) @(posedge wb_clk);
        #1; wb_rst_n = 1'b1;
      end
    join
    sb.delete(); ovr_m = 1'b0; ferr_m = 1'b0;
    repeat (10) @(negedge wb_clk);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL rmf_irq got %b required 0", irq); end
    bus(1'b1, 1'b0, 0, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL rmf_status got %h required 0", rd); end
  endtask

  initial begin
    wb_rst_n = 1'b0; rx = 1'b1;
    wb_dbus_adr = '0; wb_dbus_dat = '0; wb_dbus_sel = 4'hF; wb_dbus_we = 1'b0; wb_dbus_cyc = 1'b0;
    ovr_m = 1'b0; ferr_m = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_ferr();
    test_overflow();
    test_push_pop_full();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
